// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared widths, memory mode encodings and FSM states for the load/store unit memory controller.
package lsu_mem_ctrl_pkg;

    localparam int unsigned LSU_WIDTH = 32;

    localparam logic [1:0] MODE_WORD = 2'd0;
    localparam logic [1:0] MODE_HALF = 2'd1;
    localparam logic [1:0] MODE_BYTE = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StWait,
        StDone
    } lsu_state_e;

    // Requests that must complete with an error and never touch the bus.
    function automatic logic lsu_req_bad(input logic [1:0] mode, input logic [1:0] addr_lo);
        return (mode == 2'd3) ||
               (mode == MODE_WORD && addr_lo != 2'b00) ||
               (mode == MODE_HALF && addr_lo[0]);
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extension: memory returns half/byte right-justified, upper bits are don't-care.
module lsu_load_ext
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = LSU_WIDTH
) (
    input  logic [1:0]       mode,
    input  logic             sgn,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] ext
);

    always_comb begin
        ext = raw;
        unique case (mode)
            MODE_HALF: ext = {{(WIDTH-16){sgn & raw[15]}}, raw[15:0]};
            MODE_BYTE: ext = {{(WIDTH-8){sgn & raw[7]}}, raw[7:0]};
            default:   ext = raw;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Initiator side of the data-memory bus: turns single load/store requests into setup/strobe/hold
// bus phases, waits for the read-status flag on loads and returns extended data or an error.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = LSU_WIDTH,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_mode,
    input  logic             req_signed,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic             resp_err,
    output logic [WIDTH-1:0] resp_rdata,
    output logic [WIDTH-1:0] mem_add,
    inout  wire  [WIDTH-1:0] mem_data,
    output logic             mem_wr,
    output logic             mem_rd,
    input  logic             mem_rd_st,
    output logic [1:0]       mem_mode
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    lsu_state_e       state_q;
    logic             we_q;
    logic [1:0]       mode_q;
    logic             sgn_q;
    logic [WIDTH-1:0] wdata_q;
    logic             data_oe_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] load_ext;

    assign req_ready = (state_q == StIdle);
    assign mem_data  = data_oe_q ? wdata_q : {WIDTH{1'bz}};

    lsu_load_ext #(
        .WIDTH(WIDTH)
    ) u_load_ext (
        .mode(mode_q),
        .sgn (sgn_q),
        .raw (mem_data),
        .ext (load_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            mode_q     <= MODE_WORD;
            sgn_q      <= 1'b0;
            wdata_q    <= '0;
            data_oe_q  <= 1'b0;
            cnt_q      <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_add    <= '0;
            mem_mode   <= MODE_WORD;
            mem_wr     <= 1'b0;
            mem_rd     <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        mode_q  <= req_mode;
                        sgn_q   <= req_signed;
                        wdata_q <= req_wdata;
                        if (lsu_req_bad(req_mode, req_addr[1:0])) begin
                            state_q    <= StDone;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state_q   <= StSetup;
                            mem_add   <= req_addr;
                            mem_mode  <= req_mode;
                            data_oe_q <= req_we;
                        end
                    end
                end
                StSetup: begin
                    state_q <= StStrobe;
                    if (we_q) mem_wr <= 1'b1;
                    else      mem_rd <= 1'b1;
                end
                StStrobe: begin
                    cnt_q <= '0;
                    if (we_q) begin
                        mem_wr  <= 1'b0;
                        state_q <= StHold;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StHold: begin
                    data_oe_q  <= 1'b0;
                    state_q    <= StDone;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                StWait: begin
                    // A completion flag on the last allowed cycle still wins over the timeout.
                    if (mem_rd_st) begin
                        mem_rd     <= 1'b0;
                        state_q    <= StDone;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_ext;
                    end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        mem_rd     <= 1'b0;
                        state_q    <= StDone;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q    <= StIdle;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl with a big-endian byte memory model on the strobe bus.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_mode;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_add;
    wire  [31:0] mem_data;
    logic        mem_wr;
    logic        mem_rd;
    logic        mem_rd_st;
    logic [1:0]  mem_mode;

    logic        tb_oe;
    logic [31:0] tb_rdata;
    logic [31:0] rd_word;
    logic [7:0]  mem [0:255];
    int          rd_lat;
    bit          no_resp;
    int          wr_rises;
    int          rd_rises;
    int          n_cmp;
    int          n_err;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb_q[$];

    assign mem_data = tb_oe ? tb_rdata : 32'hzzzz_zzzz;

    always #5 clk = ~clk;

    lsu_mem_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_mode  (req_mode),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_err  (resp_err),
        .resp_rdata(resp_rdata),
        .mem_add   (mem_add),
        .mem_data  (mem_data),
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .mem_rd_st (mem_rd_st),
        .mem_mode  (mem_mode)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory writes on the rising edge of mem_wr.
    always @(posedge mem_wr) begin
        wr_rises++;
        case (mem_mode)
            2'd2: mem[mem_add[7:0]] = mem_data[7:0];
            2'd1: begin
                mem[mem_add[7:0]]      = mem_data[15:8];
                mem[mem_add[7:0] + 1]  = mem_data[7:0];
            end
            default: begin
                mem[mem_add[7:0]]      = mem_data[31:24];
                mem[mem_add[7:0] + 1]  = mem_data[23:16];
                mem[mem_add[7:0] + 2]  = mem_data[15:8];
                mem[mem_add[7:0] + 3]  = mem_data[7:0];
            end
        endcase
    end

    // Memory reads on the rising edge of mem_rd; garbage in unused upper bits.
    always @(posedge mem_rd) begin
        rd_rises++;
        case (mem_mode)
            2'd2: rd_word = {24'h5a5a5a, mem[mem_add[7:0]]};
            2'd1: rd_word = {16'ha5a5, mem[mem_add[7:0]], mem[mem_add[7:0] + 1]};
            default: rd_word = {mem[mem_add[7:0]], mem[mem_add[7:0] + 1],
                                mem[mem_add[7:0] + 2], mem[mem_add[7:0] + 3]};
        endcase
        if (!no_resp) begin
            repeat (rd_lat) @(posedge clk);
            #1;
            if (mem_rd) begin
                tb_rdata  = rd_word;
                tb_oe     = 1'b1;
                mem_rd_st = 1'b1;
            end
        end
        if (mem_rd) @(negedge mem_rd);
        tb_oe     = 1'b0;
        mem_rd_st = 1'b0;
    end

    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("resp_err", 32'(resp_err), 32'(e.err));
                check_eq("resp_rdata", resp_rdata, e.rdata);
            end
        end
    end

    task automatic do_req(input string tag, input logic we, input logic [1:0] mode,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
        int lat;
        int guard;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_we     = we;
        req_mode   = mode;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        sb_q.push_back('{exp_err, exp_rdata});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 60) begin
            if (we && !exp_err && lat <= 3) begin
                check_eq({tag, "_data"}, mem_data, wdata);
                check_eq({tag, "_wr"}, 32'(mem_wr), 32'(lat == 2));
            end
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        int wr0;
        int rd0;
        tb_oe = 1'b0; tb_rdata = '0; mem_rd_st = 1'b0; rd_word = '0;
        rd_lat = 1; no_resp = 1'b0; wr_rises = 0; rd_rises = 0; n_cmp = 0; n_err = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        req_valid = 1'b0; req_we = 1'b0; req_mode = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_strobes", {30'd0, mem_wr, mem_rd}, 32'd0);
        check_eq("rst_mem_add", mem_add, 32'd0);
        check_eq("rst_mem_mode", 32'(mem_mode), 32'd0);
        check_eq("rst_mem_data_z", 32'(mem_data === 32'hzzzz_zzzz), 32'd1);

        do_req("st_word", 1'b1, 2'd0, 1'b0, 32'h10, 32'hdeadbeef, 1'b0, 32'h0, 4);
        check_eq("mem_10_13", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'hdeadbeef);
        @(posedge clk);
        #1;
        check_eq("st_data_released", 32'(mem_data === 32'hzzzz_zzzz), 32'd1);

        do_req("ld_byte_s", 1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 1'b0, 32'hffffffde, 4);
        rd_lat = 3;
        do_req("ld_byte_u", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'h000000de, 6);
        rd_lat = 1;
        do_req("ld_half_s", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0, 32'hffffbeef, 4);
        do_req("ld_half_u", 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0000dead, 4);
        do_req("ld_word", 1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 1'b0, 32'hdeadbeef, 4);

        wr0 = wr_rises;
        rd0 = rd_rises;
        do_req("err_word", 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0, 1);
        do_req("err_half", 1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0, 1);
        do_req("err_mode3", 1'b1, 2'd3, 1'b0, 32'h10, 32'h1, 1'b1, 32'h0, 1);
        check_eq("err_no_wr", 32'(wr_rises - wr0), 32'd0);
        check_eq("err_no_rd", 32'(rd_rises - rd0), 32'd0);

        // Back-to-back: req_valid held high, second accept only once back in idle.
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_we = 1'b1; req_mode = 2'd0; req_signed = 1'b0; req_addr = 32'h20;
        req_wdata = 32'h12345678; req_valid = 1'b1;
        sb_q.push_back('{1'b0, 32'h0});
        sb_q.push_back('{1'b0, 32'h0});
        @(posedge clk);
        #1;
        for (int c = 1; c <= 5; c++) begin
            check_eq($sformatf("b2b_ready_c%0d", c), 32'(req_ready), 32'(c == 5));
            check_eq($sformatf("b2b_resp_c%0d", c), 32'(resp_valid), 32'(c == 4));
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check_eq("b2b_second_busy", 32'(req_ready), 32'd0);
        for (int c = 6; c <= 9; c++) begin
            check_eq($sformatf("b2b2_resp_c%0d", c), 32'(resp_valid), 32'(c == 9));
            @(posedge clk);
            #1;
        end
        check_eq("mem_20_23", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}, 32'h12345678);

        do_req("st_half", 1'b1, 2'd1, 1'b0, 32'h20, 32'hffff1234, 1'b0, 32'h0, 4);
        do_req("st_byte", 1'b1, 2'd2, 1'b0, 32'h22, 32'haaaaaa7f, 1'b0, 32'h0, 4);
        do_req("ld_half_new", 1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h00001234, 4);
        do_req("ld_byte_7f", 1'b0, 2'd2, 1'b1, 32'h22, 32'h0, 1'b0, 32'h0000007f, 4);
        check_eq("mem_23_kept", 32'(mem[8'h23]), 32'h78);

        no_resp = 1'b1;
        do_req("timeout", 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 19);
        check_eq("timeout_rd_low", 32'(mem_rd), 32'd0);
        @(posedge clk);
        #1;
        check_eq("timeout_idle", 32'(req_ready), 32'd1);

        // Reset while waiting on a load abandons it with no response.
        @(negedge clk);
        req_we = 1'b0; req_mode = 2'd0; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        check_eq("wait_rd_high", 32'(mem_rd), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("mid_rst_ready", 32'(req_ready), 32'd1);
        check_eq("mid_rst_strobes", {30'd0, mem_wr, mem_rd}, 32'd0);
        check_eq("mid_rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        check_eq("mid_rst_add", mem_add, 32'd0);
        repeat (20) @(negedge clk);
        no_resp = 1'b0;
        do_req("ld_after_rst", 1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 1'b0, 32'h000000ad, 4);

        repeat (3) @(negedge clk);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
